gba_rom_loader: RTL and testbench
=================================

# gba_rom_loader

Ingests the 16-bit `ioctl` download stream from `hps_io` and turns it into 32-bit word writes for the BIOS and cartridge memories, with a bounded FIFO and `ioctl_wait` backpressure. It sits between `hps_io` and the BIOS/cart memory write ports. It also owns the core reset sequencing: it holds the GBA in reset until the first download completes, and for a fixed hold period after every download.

## Interface
- `ADDR_W`, 23: word-address width; 32 MB / 4.
- `FIFO_DEPTH`, 4: packed-word FIFO entries; power of two, ≥ 2.
- `RESET_HOLD`, 255: `core_reset` hold cycles after the drain completes.

- `clk_sys`  in  1  sole clock; the `ioctl` and memory sides are both synchronous to it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  0 = BIOS, otherwise cart.
- `ioctl_wr`  in  1  halfword strobe.
- `ioctl_addr`  in  25  byte address, even.
- `ioctl_dout`  in  16  halfword data.
- `ioctl_wait`  out  1  backpressure to `hps_io`.
- `mem_req`  out  1  write request.
- `mem_ready`  in  1  memory accepts when `mem_req && mem_ready`.
- `mem_sel`  out  1  0 = BIOS, 1 = cart.
- `mem_addr`  out  `ADDR_W`  word address.
- `mem_data`  out  32  write data.
- `mem_be`  out  4  byte enables.
- `cart_words`  out  `ADDR_W+1`  cart words committed in the last/current download.
- `overflow`  out  1  sticky: write dropped because the FIFO was full.
- `busy`  out  1  state ≠ IDLE.
- `core_reset`  out  1  active-high GBA reset.
- `checksum`  out  32  see Configuration.

## Operation
- **Reset values:** `ioctl_wait`=0, `mem_req`=0, `mem_addr`/`mem_data`/`mem_be`/`mem_sel`=0, `cart_words`=0, `overflow`=0, `busy`=0, `core_reset`=1, `checksum`=0. The FIFO is emptied and the half-register is invalid.
- **FSM states:**
  - IDLE → LOAD on `ioctl_download` rising. Entering LOAD clears `cart_words`, `overflow` and `checksum`.
  - LOAD → FLUSH on `ioctl_download` low.
  - FLUSH → HOLD once the half-register is invalid and the FIFO is empty.
  - HOLD counts `RESET_HOLD` cycles → IDLE.
  - `ioctl_download` rising in FLUSH, HOLD or IDLE → LOAD. In FLUSH this applies only after the drain completes.
- **Packing:**
  - `ioctl_wr` with `ioctl_addr[1]`=0 latches the low half, the word address `ioctl_addr[24:2]`, and `mem_sel = (ioctl_index != 0)`.
  - `ioctl_addr[1]`=1 pushes `{dout, low}` with `be`=4'hF. If no low half is valid, it pushes `{dout, 16'h0}` with `be`=4'hC.
  - A low half followed by a different word address pushes the pending half first, with `be`=4'h3, upper bits 0.
  - In FLUSH, a pending low half is pushed with `be`=4'h3.
- **Backpressure:**
  - `ioctl_wait` is registered, = (FIFO count ≥ `FIFO_DEPTH`-1), and is also 1 while a flush push is pending.
  - A write arriving when the FIFO is full is dropped and sets `overflow`.
- **Memory side:**
  - `mem_req` is high whenever the FIFO is non-empty, and the head entry is presented.
  - All `mem_*` fields are stable while `mem_req && !mem_ready`.
  - The entry is popped on `mem_req && mem_ready`.
  - Each cart pop increments `cart_words`, saturating at the all-ones value.
- **`core_reset`:** 1 from reset until the first HOLD expires, 1 in LOAD, FLUSH and HOLD, and 0 only in IDLE after at least one complete download.
- **Simultaneous push and pop:** the count is unchanged. A pop on a full FIFO frees a slot for the same-cycle push.

## Timing
- `ioctl_wr` → `mem_req` for a full word is 2 cycles: the high-half latch, then the FIFO head registered.
- Back-to-back halfwords yield sustained throughput of 1 word per 2 cycles with `mem_ready`=1.
- `ioctl_wait` rises the cycle after the count reaches `FIFO_DEPTH`-1. The one write already in flight fits in the last slot.
- `core_reset` falls exactly `RESET_HOLD` cycles after the FLUSH→HOLD transition.

## Configuration
- **`GBA_LOADER_CHECKSUM_EN` defined:** `checksum` is a running 32-bit wrapping sum of `mem_data & bytemask(mem_be)` over every cart pop. It is cleared on LOAD entry.
- **Not defined:** `checksum` is tied to 0 and the adder is removed.

## Structure
- **Package `gba_loader_pkg`:**
  - state enum `{IDLE, LOAD, FLUSH, HOLD}`
  - `fifo_entry_t` struct `{sel, addr[ADDR_W], data[32], be[4]}`
  - `BIOS_INDEX`=8'd0
- **Sub-module `gba_loader_fifo`:** synchronous FIFO of `fifo_entry_t` with count output, registered head, and async active-low clear.

## Test plan
- **BIOS load:** index 0, halfwords 0x1111 @0, 0x2222 @2, 0x3333 @4, 0x4444 @6, `mem_ready`=1 → two writes: addr 0 data 0x22221111 `be` F, then addr 1 data 0x44443333; `mem_sel`=0; `cart_words`=0.
- **Odd-length cart:** index 1, three halfwords ending 0xBEEF @8 → final write addr 2 data 0x0000BEEF `be` 3; `cart_words`=2.
- **Backpressure:** `mem_ready`=0 and 8 halfwords with `hps_io` honouring `ioctl_wait` → `ioctl_wait`=1 after the third word, 0 dropped, `overflow`=0. Releasing `mem_ready` delivers all 4 words in order.
- **Overflow:** ignore `ioctl_wait` with `mem_ready`=0 and 12 halfwords → 4 words stored, `overflow`=1, and the 5th and 6th words are never requested.
- **Reset sequencing:** `core_reset`=1 out of reset. It stays 1 through the load, falls exactly 255 cycles after the drain, and rises again on the next `ioctl_download`.
- **Reset mid-load:** `reset_n` pulsed with 2 words queued → `mem_req`=0 immediately and all outputs at their reset values. With the macro enabled, a load of 0x00000001 ×3 gives `checksum`=3.

Source files
------------

// File: rtl/gba_loader_pkg.sv
// Shared types for the GBA ROM loader: FSM states, FIFO entry layout and byte-mask helper.
package gba_loader_pkg;

   localparam int         WORD_ADDR_W = 23;
   localparam logic [7:0] BIOS_INDEX  = 8'd0;
   localparam logic [3:0] BE_LO       = 4'h3;
   localparam logic [3:0] BE_HI       = 4'hC;
   localparam logic [3:0] BE_ALL      = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      HOLD  = 2'd3
   } state_e;

   typedef struct packed {
      logic                   sel;
      logic [WORD_ADDR_W-1:0] addr;
      logic [31:0]            data;
      logic [3:0]             be;
   } fifo_entry_t;

   function automatic logic [31:0] bytemask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/gba_loader_fifo.sv
// Synchronous FIFO of packed word writes; head entry is read straight from the storage registers.
module gba_loader_fifo
   import gba_loader_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  fifo_entry_t              push_data_i,
   input  logic                     pop_i,
   output fifo_entry_t              head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

   fifo_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push, do_pop;

   // A pop on a full FIFO frees the slot for a same-cycle push.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/gba_rom_loader.sv
// Packs the 16-bit hps_io download stream into 32-bit BIOS/cart writes and sequences the GBA reset.
// Optional running cart checksum is built when GBA_LOADER_CHECKSUM_EN is defined.
module gba_rom_loader
   import gba_loader_pkg::*;
#(
   parameter int ADDR_W     = WORD_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int RESET_HOLD = 255
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [15:0]       ioctl_dout,
   output logic              ioctl_wait,
   output logic              mem_req,
   input  logic              mem_ready,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic [3:0]        mem_be,
   output logic [ADDR_W:0]   cart_words,
   output logic              overflow,
   output logic              busy,
   output logic              core_reset,
   output logic [31:0]       checksum,
   output state_e            dbg_state
);

   localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] WAIT_LVL  = CNT_W'(FIFO_DEPTH - 1);
   localparam int              HOLD_W    = $clog2(RESET_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   state_e            state_q, state_d;
   logic              dl_q, dl_rise, load_entry;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              done_q, done_d;
   fifo_entry_t       half_q, half_d, stage_q, stage_d, head;
   logic              half_vld_q, half_vld_d, stage_vld_q, stage_vld_d;
   logic              wait_q, overflow_q;
   logic [ADDR_W:0]   cart_words_q;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty, pop, drop, drained;
   logic              accept, same_word, half_is_low, wr_sel;
   logic [WORD_ADDR_W-1:0] wr_addr;
   logic              unused_bits;

   assign unused_bits = ioctl_addr[0];

   gba_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i       (clk_sys),
      .rst_ni      (reset_n),
      .push_i      (stage_vld_q),
      .push_data_i (stage_q),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign pop     = !fifo_empty && mem_ready;
   assign drop    = stage_vld_q && fifo_full && !pop;
   assign drained = !half_vld_q && !stage_vld_q && fifo_empty;
   assign dl_rise = ioctl_download && !dl_q;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = done_q;
      load_entry = 1'b0;
      case (state_q)
         IDLE: if (dl_rise) begin
            state_d    = LOAD;
            load_entry = 1'b1;
         end
         LOAD: if (!ioctl_download) state_d = FLUSH;
         // Download was low on entry, so a high level here is a fresh request.
         FLUSH: if (drained) begin
            if (ioctl_download) begin
               state_d    = LOAD;
               load_entry = 1'b1;
            end else begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (dl_rise) begin
               state_d    = LOAD;
               load_entry = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Half-register packing: at most one entry enters the stage register per cycle.
   assign wr_addr     = ioctl_addr[24:2];
   assign wr_sel      = (ioctl_index != BIOS_INDEX);
   assign accept      = ioctl_wr && (state_q == LOAD);
   assign same_word   = half_vld_q && (half_q.addr == wr_addr);
   assign half_is_low = (half_q.be == BE_LO);

   always_comb begin
      half_d      = half_q;
      half_vld_d  = half_vld_q;
      stage_d     = stage_q;
      stage_vld_d = 1'b0;
      if (accept) begin
         if (!ioctl_addr[1]) begin
            if (half_vld_q && (!same_word || !half_is_low)) begin
               stage_d     = half_q;
               stage_vld_d = 1'b1;
            end
            half_d     = '{sel: wr_sel, addr: wr_addr, data: {16'h0, ioctl_dout}, be: BE_LO};
            half_vld_d = 1'b1;
         end else if (same_word && half_is_low) begin
            stage_d             = half_q;
            stage_d.data[31:16] = ioctl_dout;
            stage_d.be          = BE_ALL;
            stage_vld_d         = 1'b1;
            half_vld_d          = 1'b0;
         end else if (half_vld_q) begin
            // Orphan high half is parked and sent on the following cycle.
            stage_d     = half_q;
            stage_vld_d = 1'b1;
            half_d      = '{sel: wr_sel, addr: wr_addr, data: {ioctl_dout, 16'h0}, be: BE_HI};
            half_vld_d  = 1'b1;
         end else begin
            stage_d     = '{sel: wr_sel, addr: wr_addr, data: {ioctl_dout, 16'h0}, be: BE_HI};
            stage_vld_d = 1'b1;
         end
      end else if (half_vld_q && (!half_is_low || state_q == FLUSH)) begin
         stage_d     = half_q;
         stage_vld_d = 1'b1;
         half_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         dl_q         <= 1'b0;
         hold_cnt_q   <= '0;
         done_q       <= 1'b0;
         half_q       <= '0;
         half_vld_q   <= 1'b0;
         stage_q      <= '0;
         stage_vld_q  <= 1'b0;
         wait_q       <= 1'b0;
         overflow_q   <= 1'b0;
         cart_words_q <= '0;
      end else begin
         state_q     <= state_d;
         dl_q        <= ioctl_download;
         hold_cnt_q  <= hold_cnt_d;
         done_q      <= done_d;
         half_q      <= half_d;
         half_vld_q  <= half_vld_d;
         stage_q     <= stage_d;
         stage_vld_q <= stage_vld_d;
         wait_q      <= (fifo_count >= WAIT_LVL) || ((state_q == FLUSH) && half_vld_q);
         if (load_entry) begin
            overflow_q   <= 1'b0;
            cart_words_q <= '0;
         end else begin
            if (drop) overflow_q <= 1'b1;
            if (pop && head.sel && (cart_words_q != '1)) cart_words_q <= cart_words_q + 1'b1;
         end
      end
   end

`ifdef GBA_LOADER_CHECKSUM_EN
   logic [31:0] checksum_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                checksum_q <= '0;
      else if (load_entry)         checksum_q <= '0;
      else if (pop && head.sel)    checksum_q <= checksum_q + (head.data & bytemask(head.be));
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   assign ioctl_wait = wait_q;
   assign mem_req    = !fifo_empty;
   assign mem_sel    = head.sel;
   assign mem_addr   = head.addr;
   assign mem_data   = head.data;
   assign mem_be     = head.be;
   assign cart_words = cart_words_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != IDLE);
   assign core_reset = !((state_q == IDLE) && done_q);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_gba_rom_loader.sv
// Directed bench for gba_rom_loader: scoreboard of expected memory writes plus reset-sequencing checks.
module tb_gba_rom_loader;
   import gba_loader_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   logic        mem_req;
   logic        mem_ready;
   logic        mem_sel;
   logic [22:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_be;
   logic [23:0] cart_words;
   logic        overflow;
   logic        busy;
   logic        core_reset;
   logic [31:0] checksum;
   state_e      dbg_state;

   logic [59:0] exp_q[$];
   logic [31:0] exp_ck;
   int          n_vec = 0;
   int          n_err = 0;

   gba_rom_loader dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .mem_sel        (mem_sel),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_be         (mem_be),
      .cart_words     (cart_words),
      .overflow       (overflow),
      .busy           (busy),
      .core_reset     (core_reset),
      .checksum       (checksum),
      .dbg_state      (dbg_state)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [59:0] ent(input logic sel, input logic [22:0] a,
                                       input logic [31:0] d, input logic [3:0] be);
      return {sel, a, d, be};
   endfunction

   function automatic logic [31:0] mask_of(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic hw(input logic [24:0] a, input logic [15:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick(1);
      ioctl_wr   = 1'b0;
   endtask

   task automatic hw_honour(input logic [24:0] a, input logic [15:0] d);
      int n = 0;
      while (ioctl_wait && n < 200) begin
         tick(1);
         n++;
      end
      if (n == 200) chk("wait_stuck", 64'(ioctl_wait), 64'd0);
      hw(a, d);
   endtask

   task automatic start_download(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      exp_ck         = '0;
      tick(3);
   endtask

   task automatic wait_state(input state_e s, input int budget, input string tag);
      int n = 0;
      @(negedge clk_sys);
      while (dbg_state !== s && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
      chk(tag, 64'(dbg_state), 64'(s));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_wait"},  64'(ioctl_wait), 64'd0);
      chk({tag, "_req"},   64'(mem_req), 64'd0);
      chk({tag, "_mem"},   {4'h0, mem_sel, mem_addr, mem_data, mem_be}, 64'd0);
      chk({tag, "_cart"},  64'(cart_words), 64'd0);
      chk({tag, "_ovf"},   64'(overflow), 64'd0);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_creset"}, 64'(core_reset), 64'd1);
      chk({tag, "_cksum"}, 64'(checksum), 64'd0);
   endtask

   task automatic check_checksum(input string tag);
`ifdef GBA_LOADER_CHECKSUM_EN
      chk(tag, 64'(checksum), 64'(exp_ck));
`else
      chk(tag, 64'(checksum), 64'd0);
`endif
   endtask

   // Scoreboard: every accepted memory write must match the oldest expected entry.
   always @(negedge clk_sys) begin
      if (reset_n && mem_req && mem_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_write", 64'(exp_q.size()), 64'd1);
         end else begin
            logic [59:0] e;
            e = exp_q.pop_front();
            chk("mem_write", {4'h0, mem_sel, mem_addr, mem_data, mem_be}, {4'h0, e});
            if (e[59]) exp_ck = exp_ck + (e[35:4] & mask_of(e[3:0]));
         end
      end
   end

   initial begin
      int n;
      logic [15:0] lo, hi;
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      mem_ready      = 1'b1;
      exp_ck         = '0;
      tick(3);
      @(negedge clk_sys);
      check_reset_values("por");
      tick(1);
      reset_n = 1'b1;
      tick(2);

      // BIOS load with latency check and hold-length measurement
      start_download(8'd0);
      @(negedge clk_sys);
      chk("load_creset", 64'(core_reset), 64'd1);
      chk("load_busy", 64'(busy), 64'd1);
      tick(1);
      hw(25'd0, 16'h1111);
      exp_q.push_back(ent(1'b0, 23'd0, 32'h22221111, 4'hF));
      hw(25'd2, 16'h2222);
      @(negedge clk_sys);
      chk("lat_edge1", 64'(mem_req), 64'd0);
      @(negedge clk_sys);
      chk("lat_edge2", 64'(mem_req), 64'd1);
      tick(1);
      exp_q.push_back(ent(1'b0, 23'd1, 32'h44443333, 4'hF));
      hw(25'd4, 16'h3333);
      hw(25'd6, 16'h4444);
      tick(2);
      ioctl_download = 1'b0;
      wait_state(HOLD, 50, "bios_to_hold");
      chk("hold_entry_creset", 64'(core_reset), 64'd1);
      n = 0;
      while (core_reset === 1'b1 && n < 400) begin
         @(negedge clk_sys);
         n++;
      end
      chk("hold_len", 64'(n), 64'd255);
      chk("bios_idle", 64'(dbg_state), 64'(IDLE));
      chk("bios_drained", 64'(exp_q.size()), 64'd0);
      chk("bios_cart_words", 64'(cart_words), 64'd0);
      tick(1);

      // Odd-length cart load: trailing low half flushed with be=3
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      exp_ck         = '0;
      tick(1);
      @(negedge clk_sys);
      chk("rerise_creset", 64'(core_reset), 64'd1);
      tick(2);
      exp_q.push_back(ent(1'b1, 23'd1, 32'hF00DCAFE, 4'hF));
      exp_q.push_back(ent(1'b1, 23'd2, 32'h0000BEEF, 4'h3));
      hw(25'd4, 16'hCAFE);
      hw(25'd6, 16'hF00D);
      hw(25'd8, 16'hBEEF);
      tick(2);
      ioctl_download = 1'b0;
      wait_state(HOLD, 50, "odd_to_hold");
      chk("odd_drained", 64'(exp_q.size()), 64'd0);
      chk("odd_cart_words", 64'(cart_words), 64'd2);
      check_checksum("odd_checksum");
      tick(1);

      // Backpressure: writer honours ioctl_wait, memory stalled
      mem_ready = 1'b0;
      start_download(8'd1);
      for (int w = 0; w < 4; w++) begin
         lo = 16'($urandom_range(0, 65535));
         hi = 16'($urandom_range(0, 65535));
         exp_q.push_back(ent(1'b1, 23'h40 + 23'(w), {hi, lo}, 4'hF));
         hw_honour(25'h100 + 25'(w * 4), lo);
         hw_honour(25'h102 + 25'(w * 4), hi);
      end
      tick(2);
      @(negedge clk_sys);
      chk("bp_wait", 64'(ioctl_wait), 64'd1);
      chk("bp_ovf", 64'(overflow), 64'd0);
      chk("bp_req", 64'(mem_req), 64'd1);
      tick(3);
      @(negedge clk_sys);
      chk("bp_stall_head", {4'h0, mem_sel, mem_addr, mem_data, mem_be}, {4'h0, exp_q[0]});
      tick(1);
      mem_ready      = 1'b1;
      ioctl_download = 1'b0;
      wait_state(HOLD, 50, "bp_to_hold");
      chk("bp_drained", 64'(exp_q.size()), 64'd0);
      chk("bp_cart_words", 64'(cart_words), 64'd4);
      chk("bp_wait_low", 64'(ioctl_wait), 64'd0);
      tick(1);

      // Overflow: writer ignores ioctl_wait; words 5 and 6 must be dropped
      mem_ready = 1'b0;
      start_download(8'd1);
      for (int w = 0; w < 6; w++) begin
         lo = 16'($urandom_range(0, 65535));
         hi = 16'($urandom_range(0, 65535));
         if (w < 4) exp_q.push_back(ent(1'b1, 23'h80 + 23'(w), {hi, lo}, 4'hF));
         hw(25'h200 + 25'(w * 4), lo);
         hw(25'h202 + 25'(w * 4), hi);
      end
      tick(3);
      @(negedge clk_sys);
      chk("ovf_flag", 64'(overflow), 64'd1);
      tick(1);
      mem_ready      = 1'b1;
      ioctl_download = 1'b0;
      wait_state(HOLD, 50, "ovf_to_hold");
      chk("ovf_drained", 64'(exp_q.size()), 64'd0);
      chk("ovf_cart_words", 64'(cart_words), 64'd4);
      chk("ovf_sticky", 64'(overflow), 64'd1);
      tick(1);

      // Checksum load: three cart words of 0x00000001
      start_download(8'd1);
      @(negedge clk_sys);
      chk("ck_ovf_cleared", 64'(overflow), 64'd0);
      chk("ck_cart_cleared", 64'(cart_words), 64'd0);
      tick(1);
      for (int w = 0; w < 3; w++) begin
         exp_q.push_back(ent(1'b1, 23'(w), 32'h00000001, 4'hF));
         hw(25'(w * 4), 16'h0001);
         hw(25'(w * 4 + 2), 16'h0000);
      end
      tick(2);
      ioctl_download = 1'b0;
      wait_state(HOLD, 50, "ck_to_hold");
      chk("ck_drained", 64'(exp_q.size()), 64'd0);
      check_checksum("ck_sum");
      tick(1);

      // Reset mid-load with two words queued
      mem_ready = 1'b0;
      start_download(8'd1);
      hw(25'd0, 16'h1234);
      hw(25'd2, 16'h5678);
      hw(25'd4, 16'h9ABC);
      hw(25'd6, 16'hDEF0);
      tick(3);
      @(negedge clk_sys);
      chk("mid_req_before", 64'(mem_req), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_values("mid");
      exp_q.delete();
      ioctl_download = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      @(negedge clk_sys);
      chk("post_creset", 64'(core_reset), 64'd1);
      chk("post_state", 64'(dbg_state), 64'(IDLE));
      chk("post_req", 64'(mem_req), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
